// File: rtl/timer_disp_pkg.sv
// Shared types and constants for the two-digit seven-segment scan driver.
package timer_disp_pkg;

    typedef enum logic [1:0] {
        SHOW0 = 2'd0,
        GAP0  = 2'd1,
        SHOW1 = 2'd2,
        GAP1  = 2'd3
    } disp_state_e;

    localparam logic [6:0] SEG_OFF = 7'b000_0000;

    // Active-high {g,f,e,d,c,b,a} patterns; element 15 is listed first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1110001, // F
        7'b1111001, // E
        7'b1011110, // d
        7'b0111001, // C
        7'b1111100, // b
        7'b1110111, // A
        7'b1101111, // 9
        7'b1111111, // 8
        7'b0000111, // 7
        7'b1111101, // 6
        7'b1101101, // 5
        7'b1100110, // 4
        7'b1001111, // 3
        7'b1011011, // 2
        7'b0000110, // 1
        7'b0111111  // 0
    };

endpackage

// File: rtl/timer_display_driver_hex.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_7seg
    import timer_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = SEG_TABLE[nibble];

endmodule

// File: rtl/timer_display_driver.sv
// Two-digit multiplexed seven-segment driver with dead time, frame-boundary
// value commit and optional leading-zero blanking.
module timer_display_driver
    import timer_disp_pkg::*;
#(
    parameter int CLK_HZ      = 12000000,
    parameter int SLOT_HZ     = 1000,
    parameter int DEAD_CYCLES = 64,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       value_valid,
    input  logic [7:0] value,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] dig,
    output logic       frame_start
);

    localparam int DIV = CLK_HZ / SLOT_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - DEAD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(DEAD_CYCLES - 1);

    if (DEAD_CYCLES < 1 || DEAD_CYCLES >= DIV) begin : g_bad_dead
        $error("timer_display_driver: DEAD_CYCLES must satisfy 1 <= DEAD_CYCLES < DIV");
    end

    disp_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    display_q, display_d;
    logic [7:0]    pending_q;
    logic          pend_flag_q;
    logic          slot_last, commit;
    logic [3:0]    nibble;
    logic [6:0]    pattern, seg_hi;
    logic [1:0]    dig_hi;

    assign slot_last = (state_q == SHOW0 || state_q == SHOW1) ? (cnt_q == SHOW_LAST)
                                                              : (cnt_q == GAP_LAST);
    assign commit    = (state_q == GAP1) && slot_last;

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin : next_state_comb
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        if (slot_last) begin
            cnt_d = '0;
            case (state_q)
                SHOW0:   state_d = GAP0;
                GAP0:    state_d = SHOW1;
                SHOW1:   state_d = GAP1;
                default: state_d = SHOW0;
            endcase
        end
    end

    // A strobe on the commit edge bypasses the pending register.
    always_comb begin : commit_comb
        display_d = display_q;
        if (commit) begin
            if (value_valid)      display_d = value;
            else if (pend_flag_q) display_d = pending_q;
        end
    end

    // Outputs decode the next state so they switch on the same edge as the FSM.
    assign nibble = (state_d == SHOW1) ? display_d[7:4] : display_d[3:0];

    hex_to_7seg u_hex (
        .nibble  (nibble),
        .pattern (pattern)
    );

    always_comb begin : output_comb
        dig_hi = 2'b00;
        seg_hi = SEG_OFF;
        case (state_d)
            SHOW0: begin
                dig_hi = 2'b01;
                seg_hi = pattern;
            end
            SHOW1: begin
                if (!(blank_lz && display_d[7:4] == 4'h0)) begin
                    dig_hi = 2'b10;
                    seg_hi = pattern;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= GAP1;
            cnt_q       <= '0;
            display_q   <= 8'h00;
            pending_q   <= 8'h00;
            pend_flag_q <= 1'b0;
            seg         <= ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
            dig         <= ACTIVE_LOW ? 2'b11 : 2'b00;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            display_q   <= display_d;
            if (value_valid) pending_q <= value;
            pend_flag_q <= commit ? 1'b0 : (pend_flag_q | value_valid);
            seg         <= ACTIVE_LOW ? ~seg_hi : seg_hi;
            dig         <= ACTIVE_LOW ? ~dig_hi : dig_hi;
            frame_start <= commit;
        end
    end

endmodule

// File: tb/tb_timer_display_driver.sv
// Self-checking bench: an active-high and an active-low instance share stimulus
// and are compared every cycle against a frame-position reference model.
module tb_timer_display_driver;

    localparam int CLK_HZ  = 1000;
    localparam int SLOT_HZ = 100;
    localparam int DIV     = CLK_HZ / SLOT_HZ;
    localparam int DEAD    = 2;
    localparam int FRAME   = 2 * DIV;
    localparam int SHOWLEN = DIV - DEAD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       value_valid = 1'b0;
    logic [7:0] value = 8'h00;
    logic       blank_lz = 1'b0;
    logic [6:0] seg, seg_n;
    logic [1:0] dig, dig_n;
    logic       frame_start, frame_start_n;

    timer_display_driver #(.CLK_HZ(CLK_HZ), .SLOT_HZ(SLOT_HZ), .DEAD_CYCLES(DEAD), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .value_valid(value_valid), .value(value), .blank_lz(blank_lz),
        .seg(seg), .dig(dig), .frame_start(frame_start)
    );

    timer_display_driver #(.CLK_HZ(CLK_HZ), .SLOT_HZ(SLOT_HZ), .DEAD_CYCLES(DEAD), .ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst(rst), .value_valid(value_valid), .value(value), .blank_lz(blank_lz),
        .seg(seg_n), .dig(dig_n), .frame_start(frame_start_n)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    // Reference model: k counts edges since the last reset edge; frame position
    // 0 is the first SHOW0 cycle, reached DEAD edges after reset.
    int         m_k = 0;
    int         m_pos;
    logic [7:0] m_disp = 8'h00;
    logic [7:0] m_pend = 8'h00;
    bit         m_pv = 1'b0;
    logic [6:0] e_seg = 7'h00, e_seg_n = 7'h7f;
    logic [1:0] e_dig = 2'b00, e_dig_n = 2'b11;
    logic       e_fs = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_k = 0; m_disp = 8'h00; m_pend = 8'h00; m_pv = 1'b0;
        end else begin
            m_k++;
            if ((m_k + FRAME - DEAD) % FRAME == 0) begin
                if (value_valid) m_disp = value;
                else if (m_pv)   m_disp = m_pend;
                m_pv = 1'b0;
            end else if (value_valid) begin
                m_pend = value;
                m_pv   = 1'b1;
            end
        end
        m_pos = (m_k + FRAME - DEAD) % FRAME;
        e_fs  = !rst && (m_pos == 0);
        e_dig = 2'b00;
        e_seg = 7'h00;
        if (m_pos < SHOWLEN) begin
            e_dig = 2'b01; e_seg = ref_seg(m_disp[3:0]);
        end else if (m_pos >= DIV && m_pos < DIV + SHOWLEN && !(blank_lz && m_disp[7:4] == 4'h0)) begin
            e_dig = 2'b10; e_seg = ref_seg(m_disp[7:4]);
        end
        e_seg_n = ~e_seg;
        e_dig_n = ~e_dig;
    end

    // Per-cycle comparison of both instances plus a dead-time monitor.
    logic [1:0] prev_dig = 2'b00;
    int         dark_run = 0;
    bit         seen_dig = 1'b0;

    always @(negedge clk) begin
        check("seg", seg, e_seg);
        check("dig", dig, e_dig);
        check("frame_start", frame_start, e_fs);
        check("seg_active_low", seg_n, e_seg_n);
        check("dig_active_low", dig_n, e_dig_n);
        check("frame_start_active_low", frame_start_n, e_fs);
        if (dig != 2'b00 && prev_dig == 2'b00) begin
            if (seen_dig) check("dead_time_ok", dark_run >= DEAD, 1);
            seen_dig = 1'b1;
        end
        dark_run = (dig == 2'b00) ? dark_run + 1 : 0;
        prev_dig = dig;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_start) return;
        end
        check("frame_start_timeout", 0, 1);
    endtask

    task automatic strobe(input logic [7:0] v);
        value = v;
        value_valid = 1'b1;
        step(1);
        value_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] val;
        logic       blank;
        logic [6:0] seg0;
        logic [1:0] dig1;
        logic [6:0] seg1;
    } vec_t;

    vec_t vecs[6];
    int   n0, n1;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 7'b1101101, 2'b10, 7'b1110111};
        vecs[1] = '{8'h07, 1'b1, 7'b0000111, 2'b00, 7'b0000000};
        vecs[2] = '{8'h07, 1'b0, 7'b0000111, 2'b10, 7'b0111111};
        vecs[3] = '{8'h3C, 1'b1, 7'b0111001, 2'b10, 7'b1001111};
        vecs[4] = '{8'h0B, 1'b1, 7'b1111100, 2'b00, 7'b0000000};
        vecs[5] = '{8'hE8, 1'b0, 7'b1111111, 2'b10, 7'b1111001};

        // Reset release: two dark cycles, then SHOW0 of 00 with frame_start.
        step(3);
        check("reset_seg_n_all_ones", seg_n, 7'h7f);
        rst = 1'b0;
        check("post_reset_dig_0", dig, 2'b00);
        step(1);
        check("post_reset_dig_1", dig, 2'b00);
        check("post_reset_fs_1", frame_start, 1'b0);
        step(1);
        check("first_frame_start", frame_start, 1'b1);
        check("first_dig", dig, 2'b01);
        check("first_seg", seg, 7'b0111111);
        n0 = 1; n1 = 0;
        for (int i = 1; i < FRAME; i++) begin
            step(1);
            if (dig == 2'b01) n0++;
            if (dig == 2'b10) n1++;
        end
        check("show0_len", n0, SHOWLEN);
        check("show1_len", n1, SHOWLEN);

        // Table vectors: strobe mid-SHOW0, verify both digits in the next frame.
        foreach (vecs[i]) begin
            wait_fs(2 * FRAME);
            step(3);
            blank_lz = vecs[i].blank;
            strobe(vecs[i].val);
            wait_fs(2 * FRAME);
            check($sformatf("vec%0d_dig0", i), dig, 2'b01);
            check($sformatf("vec%0d_seg0", i), seg, vecs[i].seg0);
            step(DIV);
            check($sformatf("vec%0d_dig1", i), dig, vecs[i].dig1);
            check($sformatf("vec%0d_seg1", i), seg, vecs[i].seg1);
        end
        blank_lz = 1'b0;

        // Two strobes in one frame: the last wins.
        wait_fs(2 * FRAME);
        step(2);
        strobe(8'h12);
        step(4);
        strobe(8'h34);
        wait_fs(2 * FRAME);
        check("last_wins_seg0", seg, ref_seg(4'h4));
        step(DIV);
        check("last_wins_seg1", seg, ref_seg(4'h3));

        // Strobe on the commit edge shows in that same frame.
        wait_fs(2 * FRAME);
        step(FRAME - 1);
        strobe(8'h9F);
        check("commit_edge_fs", frame_start, 1'b1);
        check("commit_edge_seg0", seg, 7'b1110001);
        step(DIV);
        check("commit_edge_seg1", seg, 7'b1101111);
        wait_fs(2 * FRAME);
        check("no_stale_pending", seg, 7'b1110001);

        // Reset in GAP1 with a pending value discards it.
        step(FRAME - DEAD);
        strobe(8'h88);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        wait_fs(2 * FRAME);
        check("reset_discard_seg0", seg, 7'b0111111);
        step(DIV);
        check("reset_discard_seg1", seg, 7'b0111111);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            value_valid = ($urandom_range(0, 15) == 0);
            value       = 8'($urandom);
            if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
            rst = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        value_valid = 1'b0;
        step(FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_display_driver.md
# timer_display_driver

Multiplexed two-digit seven-segment driver downstream of the 4-bit LED timer: it accepts an 8-bit count value (two hex digits) on a valid strobe and scans it onto a common-segment, two-digit display. Includes refresh timing, anti-ghosting dead time between digits, tear-free value commit at frame boundaries, and optional leading-zero blanking. Runs on the 12 MHz board clock.

## Interface
- CLK_HZ, 12000000: input clock frequency.
- SLOT_HZ, 1000: digit slot rate; slot length DIV = CLK_HZ/SLOT_HZ cycles (12000 by default).
- DEAD_CYCLES, 64: dead time at the end of each slot; requires 1 <= DEAD_CYCLES < DIV (elaboration error otherwise).
- ACTIVE_LOW, 1: 1 = seg and dig are active-low (common anode); 0 = active-high.
- clk  in  1  12 MHz clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- value_valid  in  1  one-cycle strobe; captures value.
- value  in  8  [3:0] = digit 0 (right), [7:4] = digit 1 (left).
- blank_lz  in  1  when 1 and the displayed high nibble is 0, digit 1 stays dark.
- seg  out  7  segments {g,f,e,d,c,b,a}; seg[0] = a.
- dig  out  2  one-hot digit enable; dig[0] = right digit.
- frame_start  out  1  one-cycle pulse on the cycle the committed display value changes slot to digit 0.

## Operation
- State machine: SHOW0 -> GAP0 -> SHOW1 -> GAP1 -> SHOW0. SHOWn lasts DIV-DEAD_CYCLES cycles, GAPn lasts DEAD_CYCLES; one frame = 2*DIV cycles.
- Slot counter width = clog2(DIV); counts 0..(state length - 1), reloads to 0 on every state change; no other wrap.
- SHOWn: dig[n] active, other inactive, seg = encoding of nibble n of display register. GAPn: both dig inactive, seg all inactive.
- Leading-zero blank: in SHOW1 with blank_lz=1 and display[7:4]=0, dig and seg both inactive (looks like GAP). blank_lz sampled live each cycle. Digit 0 is never blanked.
- Capture: value_valid=1 loads pending register and sets pending flag. Several strobes in one frame: last wins.
- Commit: on the GAP1 -> SHOW0 transition edge, if pending flag set, display <= pending, flag cleared. If value_valid is high on that same cycle, the strobed value is committed directly and flag ends clear.
- Encoding (active-high form, gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001. ACTIVE_LOW inverts seg and dig.

## Timing
- seg, dig, frame_start are registered, decoded from next state so they change on the same edge as the state.
- Reset (rst high at an edge): state GAP1, counter 0, display = 0x00, pending = 0x00, flag clear; seg and dig inactive, frame_start 0. Reset mid-frame discards any pending value.
- After rst deasserts: DEAD_CYCLES cycles of GAP1, then SHOW0 with frame_start pulsed.
- Value-to-display latency: from strobe to the next frame_start, at most 2*DIV cycles, at least 1 cycle.
- A digit enable never overlaps the other; at least DEAD_CYCLES inactive cycles between any two dig assertions.

## Structure
- Shared package timer_disp_pkg: state enum (SHOW0, GAP0, SHOW1, GAP1), 16-entry segment constant table, SEG_OFF constant.
- One sub-module: hex_to_7seg (4-bit nibble -> 7-bit active-high pattern, combinational), instantiated once, fed by a nibble mux.
- Top holds FSM, slot counter, capture/commit registers, polarity inversion, output registers.

## Test plan
Use CLK_HZ=1000, SLOT_HZ=100 (DIV=10), DEAD_CYCLES=2, ACTIVE_LOW=0.
- Reset then release -> 2 cycles dig=00/seg=0; then frame_start=1, dig=01, seg=0111111 for 8 cycles; 2 dark; dig=10, seg=0111111 for 8; repeat every 20 cycles.
- Strobe value=0xA5 mid-SHOW0 -> current frame still shows 00; after next frame_start, dig=01 seg=1101101, dig=10 seg=1110111.
- Strobes 0x12 then 0x34 in one frame -> next frame shows 4 and 3; 0x12 never appears.
- value=0x07, blank_lz=1 -> SHOW0 seg=0000111; during SHOW1 dig=00, seg=0; set blank_lz=0 -> digit 1 shows 0111111.
- Strobe 0x9F on the cycle of the GAP1->SHOW0 edge -> that same frame shows F (1110001) and 9 (1101111); pending flag clear afterward.
- Strobe 0x88, assert rst mid-GAP1 before commit -> after release display shows 00; ACTIVE_LOW=1 rerun -> seg/dig exactly inverted, all-ones during reset.
